// File: rtl/digit_layout.sv
`default_nettype none
// ============================================================================
// Module      : digit_layout
// Description : Maps raster coordinates onto a four-digit HH:MM clock face
//               with a blinking colon, tear-free time updates at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_layout #(
    parameter int PIX_X_W      = 12,
    parameter int PIX_Y_W      = 12,
    parameter int ORG_X        = 160,
    parameter int ORG_Y        = 190,
    parameter int DIG_W        = 80,
    parameter int DIG_H        = 100,
    parameter int GAP          = 16,
    parameter int COLON_W      = 32,
    parameter int DOT          = 12,
    parameter int BLINK_FRAMES = 30,
    parameter int BLANK_LZ     = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [15:0]        time_i,
    input  logic               time_vld_i,
    input  logic [PIX_X_W-1:0] pix_x_i,
    input  logic [PIX_Y_W-1:0] pix_y_i,
    input  logic               pix_vld_i,
    input  logic               sof_i,
    output logic [3:0]         num_o,
    output logic [PIX_X_W-1:0] pos_x_o,
    output logic [PIX_Y_W-1:0] pos_y_o,
    output logic               in_digit_o,
    output logic               colon_o,
    output logic               vld_o,
    output logic               bad_time_o
);

    localparam int C_PITCH = DIG_W + GAP;
    localparam int C_CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // All region bounds held at 32 bits so ORG+offset can never wrap.
    localparam logic [31:0] C_X0  = 32'(ORG_X);
    localparam logic [31:0] C_X1  = 32'(ORG_X + C_PITCH);
    localparam logic [31:0] C_XC  = 32'(ORG_X + 2 * C_PITCH);
    localparam logic [31:0] C_X2  = 32'(ORG_X + 2 * C_PITCH + COLON_W);
    localparam logic [31:0] C_X3  = 32'(ORG_X + 3 * C_PITCH + COLON_W);
    localparam logic [31:0] C_Y0  = 32'(ORG_Y);
    localparam logic [31:0] C_DW  = 32'(DIG_W);
    localparam logic [31:0] C_DH  = 32'(DIG_H);
    localparam logic [31:0] C_CW  = 32'(COLON_W);
    localparam logic [31:0] C_B1  = 32'(DIG_H / 3);
    localparam logic [31:0] C_B2  = 32'(2 * DIG_H / 3);
    localparam logic [31:0] C_DOT = 32'(DOT);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(BLINK_FRAMES - 1);

    if (DIG_W * DIG_H > 8192) begin : g_cell_size_check
        $error("digit_layout: DIG_W*DIG_H must not exceed 8192");
    end

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;

    logic [15:0]        r_pending;
    logic [15:0]        r_active;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_phase;

    logic               w_time_ok;
    logic               w_accept;
    logic               w_sof;
    logic [15:0]        w_active_nxt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               w_phase_nxt;

    logic [31:0]        w_px;
    logic [31:0]        w_py;
    logic [31:0]        w_dy;
    logic               w_in_y;
    logic [3:0]         w_hit;
    logic               w_colon_hit;
    logic [PIX_X_W-1:0] w_off_x;

    logic               r_s1_vld;
    logic [3:0]         r_s1_hit;
    logic               r_s1_colon;
    logic [PIX_X_W-1:0] r_s1_off_x;
    logic [PIX_Y_W-1:0] r_s1_off_y;
    logic [15:0]        r_s1_time;
    logic               r_s1_phase;

    logic [3:0]         w_nib;
    logic               w_show;

    logic [3:0]         r_num;
    logic [PIX_X_W-1:0] r_pos_x;
    logic [PIX_Y_W-1:0] r_pos_y;
    logic               r_in_digit;
    logic               r_colon;
    logic               r_vld;
    logic               r_bad;

    // Assertion is immediate through the synchroniser flops; release is clocked.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_time_ok = (time_i[15:12] <= 4'd9) && (time_i[11:8] <= 4'd9) &&
                       (time_i[7:4]   <= 4'd9) && (time_i[3:0]  <= 4'd9);
    assign w_accept  = time_vld_i && w_time_ok;
    assign w_sof     = sof_i && pix_vld_i;

    always_comb begin
        w_active_nxt = r_active;
        w_cnt_nxt    = r_cnt;
        w_phase_nxt  = r_phase;
        if (w_sof) begin
            w_active_nxt = w_accept ? time_i : r_pending;
            if (r_cnt == C_CNT_LAST) begin
                w_cnt_nxt   = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    assign w_px   = 32'(pix_x_i);
    assign w_py   = 32'(pix_y_i);
    assign w_dy   = w_py - C_Y0;
    assign w_in_y = pix_vld_i && (w_py >= C_Y0) && (w_py < C_Y0 + C_DH);

    assign w_hit[0] = w_in_y && (w_px >= C_X0) && (w_px < C_X0 + C_DW);
    assign w_hit[1] = w_in_y && (w_px >= C_X1) && (w_px < C_X1 + C_DW);
    assign w_hit[2] = w_in_y && (w_px >= C_X2) && (w_px < C_X2 + C_DW);
    assign w_hit[3] = w_in_y && (w_px >= C_X3) && (w_px < C_X3 + C_DW);

    assign w_colon_hit = w_in_y && (w_px >= C_XC) && (w_px < C_XC + C_CW) &&
                         (((w_dy >= C_B1) && (w_dy < C_B1 + C_DOT)) ||
                          ((w_dy >= C_B2) && (w_dy < C_B2 + C_DOT)));

    always_comb begin
        w_off_x = '0;
        if (w_hit[0])      w_off_x = PIX_X_W'(w_px - C_X0);
        else if (w_hit[1]) w_off_x = PIX_X_W'(w_px - C_X1);
        else if (w_hit[2]) w_off_x = PIX_X_W'(w_px - C_X2);
        else if (w_hit[3]) w_off_x = PIX_X_W'(w_px - C_X3);
    end

    // Stage 1 snapshots the post-sof time/phase so a frame's last pixels
    // can never pick up the next frame's value.
    always_comb begin
        w_nib = 4'd0;
        case (r_s1_hit)
            4'b0001: w_nib = r_s1_time[15:12];
            4'b0010: w_nib = r_s1_time[11:8];
            4'b0100: w_nib = r_s1_time[7:4];
            4'b1000: w_nib = r_s1_time[3:0];
            default: w_nib = 4'd0;
        endcase
    end

    assign w_show = (|r_s1_hit) &&
                    !((BLANK_LZ != 0) && r_s1_hit[0] && (r_s1_time[15:12] == 4'd0));

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pending  <= '0;
            r_active   <= '0;
            r_cnt      <= '0;
            r_phase    <= 1'b1;
            r_s1_vld   <= 1'b0;
            r_s1_hit   <= '0;
            r_s1_colon <= 1'b0;
            r_s1_off_x <= '0;
            r_s1_off_y <= '0;
            r_s1_time  <= '0;
            r_s1_phase <= 1'b0;
            r_num      <= '0;
            r_pos_x    <= '0;
            r_pos_y    <= '0;
            r_in_digit <= 1'b0;
            r_colon    <= 1'b0;
            r_vld      <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            if (w_accept) r_pending <= time_i;
            r_active   <= w_active_nxt;
            r_cnt      <= w_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_bad      <= time_vld_i && !w_time_ok;

            r_s1_vld   <= pix_vld_i;
            r_s1_hit   <= w_hit;
            r_s1_colon <= w_colon_hit;
            r_s1_off_x <= w_off_x;
            r_s1_off_y <= (|w_hit) ? PIX_Y_W'(w_dy) : '0;
            r_s1_time  <= w_active_nxt;
            r_s1_phase <= w_phase_nxt;

            r_num      <= w_show ? w_nib : 4'd0;
            r_pos_x    <= w_show ? r_s1_off_x : '0;
            r_pos_y    <= w_show ? r_s1_off_y : '0;
            r_in_digit <= w_show;
            r_colon    <= r_s1_colon && r_s1_phase;
            r_vld      <= r_s1_vld;
        end
    end

    assign num_o      = r_num;
    assign pos_x_o    = r_pos_x;
    assign pos_y_o    = r_pos_y;
    assign in_digit_o = r_in_digit;
    assign colon_o    = r_colon;
    assign vld_o      = r_vld;
    assign bad_time_o = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_digit_layout.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_layout
// Description : Directed self-checking bench for digit_layout with a
//               frame-level reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_layout;

    localparam int ORG_X = 160, ORG_Y = 190, DIG_W = 80, DIG_H = 100;
    localparam int GAP = 16, COLON_W = 32, DOT = 12, BLINK = 30;
    localparam int P = DIG_W + GAP;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] time_i = '0;
    logic        time_vld_i = 1'b0;
    logic [11:0] pix_x_i = '0;
    logic [11:0] pix_y_i = '0;
    logic        pix_vld_i = 1'b0;
    logic        sof_i = 1'b0;
    logic [3:0]  num_o;
    logic [11:0] pos_x_o;
    logic [11:0] pos_y_o;
    logic        in_digit_o, colon_o, vld_o, bad_time_o;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    digit_layout dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .time_i     (time_i),
        .time_vld_i (time_vld_i),
        .pix_x_i    (pix_x_i),
        .pix_y_i    (pix_y_i),
        .pix_vld_i  (pix_vld_i),
        .sof_i      (sof_i),
        .num_o      (num_o),
        .pos_x_o    (pos_x_o),
        .pos_y_o    (pos_y_o),
        .in_digit_o (in_digit_o),
        .colon_o    (colon_o),
        .vld_o      (vld_o),
        .bad_time_o (bad_time_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  num;
        logic [11:0] px;
        logic [11:0] py;
        logic        ind;
        logic        col;
        logic        vld;
    } exp_t;

    // Reference model: clock-face state as the display would see it.
    logic [15:0] m_pending, m_active;
    int          m_cnt;
    bit          m_phase;
    bit          m_bad;
    exp_t        pipe0, pipe1;

    function automatic exp_t predict(input int x, input int y, input bit pv);
        exp_t e;
        int   dy, xs, d, cx;
        e = '0;
        e.vld = pv;
        if (!pv) return e;
        dy = y - ORG_Y;
        if (y >= ORG_Y && y < ORG_Y + DIG_H) begin
            for (int k = 0; k < 4; k++) begin
                xs = ORG_X + k * P + ((k >= 2) ? COLON_W : 0);
                if (x >= xs && x < xs + DIG_W) begin
                    d = int'((m_active >> (4 * (3 - k))) & 16'hF);
                    if (!(k == 0 && d == 0)) begin
                        e.ind = 1'b1;
                        e.num = 4'(d);
                        e.px  = 12'(x - xs);
                        e.py  = 12'(dy);
                    end
                end
            end
            cx = ORG_X + 2 * P;
            if (x >= cx && x < cx + COLON_W && m_phase &&
                ((dy >= DIG_H / 3 && dy < DIG_H / 3 + DOT) ||
                 (dy >= 2 * DIG_H / 3 && dy < 2 * DIG_H / 3 + DOT)))
                e.col = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_pending = '0; m_active = '0; m_cnt = 0; m_phase = 1'b1;
            m_bad = 1'b0; pipe0 = '0; pipe1 = '0;
        end else begin
            bit ok, acc;
            ok = (time_i[15:12] < 10) && (time_i[11:8] < 10) &&
                 (time_i[7:4] < 10) && (time_i[3:0] < 10);
            acc = time_vld_i && ok;
            m_bad = time_vld_i && !ok;
            if (pix_vld_i && sof_i) begin
                m_active = acc ? time_i : m_pending;
                m_cnt = m_cnt + 1;
                if (m_cnt == BLINK) begin
                    m_cnt = 0;
                    m_phase = !m_phase;
                end
            end
            if (acc) m_pending = time_i;
            pipe1 = pipe0;
            pipe0 = predict(int'(pix_x_i), int'(pix_y_i), pix_vld_i);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            n_vec++;
            if ({num_o, pos_x_o, pos_y_o, in_digit_o, colon_o, vld_o, bad_time_o} !==
                {pipe1.num, pipe1.px, pipe1.py, pipe1.ind, pipe1.col, pipe1.vld, m_bad}) begin
                n_err++;
                $display("FAIL model t=%0t got num=%0h px=%0d py=%0d ind=%0b col=%0b vld=%0b bad=%0b exp num=%0h px=%0d py=%0d ind=%0b col=%0b vld=%0b bad=%0b",
                         $time, num_o, pos_x_o, pos_y_o, in_digit_o, colon_o, vld_o, bad_time_o,
                         pipe1.num, pipe1.px, pipe1.py, pipe1.ind, pipe1.col, pipe1.vld, m_bad);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int x, input int y, input bit pv, input bit sof,
                        input bit tv, input logic [15:0] t);
        @(negedge clk);
        pix_x_i = 12'(x); pix_y_i = 12'(y); pix_vld_i = pv; sof_i = sof;
        time_vld_i = tv; time_i = t;
    endtask

    task automatic idle();
        step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic sofs(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b1, 1'b1, 1'b0, 16'h0);
        idle();
    endtask

    task automatic check_out(input string name, input int num, input int px,
                             input int py, input bit ind, input bit col);
        chk({name, ".num"}, int'(num_o), num);
        chk({name, ".pos_x"}, int'(pos_x_o), px);
        chk({name, ".pos_y"}, int'(pos_y_o), py);
        chk({name, ".in_digit"}, int'(in_digit_o), int'(ind));
        chk({name, ".colon"}, int'(colon_o), int'(col));
        chk({name, ".vld"}, int'(vld_o), 1);
    endtask

    task automatic pix_chk(input string name, input int x, input int y, input int num,
                           input int px, input int py, input bit ind, input bit col);
        step(x, y, 1'b1, 1'b0, 1'b0, 16'h0);
        idle();
        idle();
        check_out(name, num, px, py, ind, col);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 rst_i = 1'b0;
        started = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.num", int'(num_o), 0);
        chk("reset.in_digit", int'(in_digit_o), 0);
        chk("reset.vld", int'(vld_o), 0);
        rst_i = 1'b1;
        repeat (4) idle();

        // Load 12:34 and display it from the next frame onward.
        step(0, 0, 1'b0, 1'b0, 1'b1, 16'h1234);
        sofs(1);
        pix_chk("c1", ORG_X + P + 5, ORG_Y + 7, 2, 5, 7, 1, 0);
        pix_chk("c0", 165, 190, 1, 5, 0, 1, 0);
        pix_chk("c3_corner", 559, 289, 4, 79, 99, 1, 0);
        pix_chk("c3_right", 560, 289, 0, 0, 0, 0, 0);
        pix_chk("c3_bottom", 559, 290, 0, 0, 0, 0, 0);
        pix_chk("gap", 240, 200, 0, 0, 0, 0, 0);
        pix_chk("left", 159, 200, 0, 0, 0, 0, 0);

        // 09:45 arrives mid-frame; visible only after the next sof.
        step(0, 0, 1'b0, 1'b0, 1'b1, 16'h0945);
        pix_chk("noTear", 165, 190, 1, 5, 0, 1, 0);
        sofs(1);
        pix_chk("blankLZ", 170, 195, 0, 0, 0, 0, 0);
        pix_chk("c1_0945", 256, 190, 9, 0, 0, 1, 0);

        // Rejected time pulses once and never reaches the display.
        step(0, 0, 1'b0, 1'b0, 1'b1, 16'h1A00);
        idle();
        chk("bad_pulse", int'(bad_time_o), 1);
        idle();
        chk("bad_clear", int'(bad_time_o), 0);
        sofs(1);
        pix_chk("afterBad.c1", 256, 190, 9, 0, 0, 1, 0);
        pix_chk("afterBad.c3", 485, 195, 5, 5, 5, 1, 0);

        // Time strobe coinciding with sof lands in that same frame.
        step(483, 192, 1'b1, 1'b1, 1'b1, 16'h2359);
        idle();
        idle();
        check_out("sameSof", 9, 3, 2, 1, 0);
        pix_chk("sameSof.c0", 160, 190, 2, 0, 0, 1, 0);

        // Colon dot bands.
        pix_chk("col.d33", 356, 223, 0, 0, 0, 0, 1);
        pix_chk("col.d44", 356, 234, 0, 0, 0, 0, 1);
        pix_chk("col.d45", 356, 235, 0, 0, 0, 0, 0);
        pix_chk("col.d66", 356, 256, 0, 0, 0, 0, 1);
        pix_chk("col.d78", 356, 268, 0, 0, 0, 0, 0);
        pix_chk("col.c2", 384, 223, 5, 0, 33, 1, 0);

        // Asynchronous reset in the middle of a line.
        step(300, 200, 1'b1, 1'b0, 1'b0, 16'h0);
        step(300, 200, 1'b1, 1'b0, 1'b0, 16'h0);
        step(300, 200, 1'b1, 1'b0, 1'b0, 16'h0);
        check_out("preRst", 3, 44, 10, 1, 0);
        #2;
        rst_i = 1'b0;
        pix_vld_i = 1'b0;
        #1;
        chk("rst.in_digit", int'(in_digit_o), 0);
        chk("rst.num", int'(num_o), 0);
        chk("rst.pos_x", int'(pos_x_o), 0);
        chk("rst.vld", int'(vld_o), 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        repeat (4) idle();

        // Blink counter restarts from zero after reset.
        pix_chk("blink0", 356, 223, 0, 0, 0, 0, 1);
        sofs(29);
        pix_chk("blink29", 356, 223, 0, 0, 0, 0, 1);
        sofs(1);
        pix_chk("blink30", 356, 223, 0, 0, 0, 0, 0);
        sofs(29);
        pix_chk("blink59", 356, 223, 0, 0, 0, 0, 0);
        sofs(1);
        pix_chk("blink60", 356, 223, 0, 0, 0, 0, 1);

        repeat (3) idle();
        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
